// File: rtl/rv_alu_mdu.sv
// RV32I/M execute unit: single-cycle base ALU, iterative MUL/DIV at XLEN+2 cycles (special-case divides at 1).
// Valid/ready on both sides; the result holds in DONE until taken, and nothing new is accepted meanwhile.
module rv_alu_mdu #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            op_m,
   input  logic [2:0]      funct3,
   input  logic            funct7b5,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            flag,
   output logic            busy
);

   localparam int SH_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   dvs;
   logic [2:0]        f3_q;
   logic              neg_res;
   logic              neg_rem;

   logic accept;
   assign in_ready = !rst && (state == S_IDLE || (state == S_DONE && out_ready));
   assign accept   = in_valid && in_ready;
   assign busy     = (state != S_IDLE);

   // Base ALU
   logic [XLEN:0]   add_w, sub_w;
   logic [SH_W-1:0] shamt;
   logic [XLEN-1:0] alu_res;
   logic            alu_flag;
   logic            alt;

   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} - {1'b0, b};
   assign shamt = b[SH_W-1:0];
   assign alt   = funct7b5 && (funct3 == 3'b000 || funct3 == 3'b101);

   always_comb begin
      alu_res  = '0;
      alu_flag = 1'b0;
      case ({funct3, alt})
         4'b0000: begin alu_res = add_w[XLEN-1:0]; alu_flag = add_w[XLEN]; end
         4'b0001: begin alu_res = sub_w[XLEN-1:0]; alu_flag = sub_w[XLEN]; end
         4'b0010: alu_res = a << shamt;
         4'b0100: alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         4'b0110: alu_res = {{(XLEN-1){1'b0}}, a < b};
         4'b1000: alu_res = a ^ b;
         4'b1010: alu_res = a >> shamt;
         4'b1011: alu_res = $unsigned($signed(a) >>> shamt);
         4'b1100: alu_res = a | b;
         4'b1110: alu_res = a & b;
         default: alu_res = '0;
      endcase
   end

   // Operand signs and magnitudes for the M group
   logic            sgn_a, sgn_b;
   logic [XLEN-1:0] mag_a, mag_b;

   always_comb begin
      if (funct3[2]) begin
         sgn_a = !funct3[0] && a[XLEN-1];
         sgn_b = !funct3[0] && b[XLEN-1];
      end else begin
         sgn_a = (funct3 == 3'b001 || funct3 == 3'b010) && a[XLEN-1];
         sgn_b = (funct3 == 3'b001) && b[XLEN-1];
      end
   end

   assign mag_a = sgn_a ? -a : a;
   assign mag_b = sgn_b ? -b : b;

   logic            div_zero, div_ovf;
   logic [XLEN-1:0] spec_res;

   assign div_zero = (b == '0);
   assign div_ovf  = !funct3[0] && (a == MIN_NEG) && (b == '1);
   assign spec_res = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

   // One shift-add multiply step: low half holds the unconsumed multiplier bits
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   // One restoring divide step: high half is the remainder, low half the dividend/quotient
   logic [XLEN:0]     div_rs, div_diff;
   logic              q_bit;
   logic [2*XLEN-1:0] div_next;
   assign div_rs   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign div_diff = div_rs - {1'b0, dvs};
   assign q_bit    = !div_diff[XLEN];
   assign div_next = {(q_bit ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]), acc[XLEN-2:0], q_bit};

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fix_res;
   assign prod    = neg_res ? -acc : acc;
   assign quo     = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
   assign rem     = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
   assign fix_res = f3_q[2] ? (f3_q[1] ? rem : quo)
                            : ((f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         flag      <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         dvs       <= '0;
         f3_q      <= '0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  f3_q    <= funct3;
                  neg_res <= sgn_a ^ sgn_b;
                  neg_rem <= sgn_a;
                  cnt     <= '0;
                  if (!op_m) begin
                     result    <= alu_res;
                     flag      <= alu_flag;
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                  end else if (!funct3[2]) begin
                     acc       <= {{XLEN{1'b0}}, mag_b};
                     dvs       <= mag_a;
                     state     <= S_MUL;
                     out_valid <= 1'b0;
                  end else if (div_zero || div_ovf) begin
                     result    <= spec_res;
                     flag      <= 1'b0;
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                  end else begin
                     acc       <= {{XLEN{1'b0}}, mag_a};
                     dvs       <= mag_b;
                     state     <= S_DIV;
                     out_valid <= 1'b0;
                  end
               end else if (state == S_DONE && out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            S_MUL: begin
               acc <= mul_next;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) state <= S_FIX;
            end
            S_DIV: begin
               acc <= div_next;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) state <= S_FIX;
            end
            S_FIX: begin
               result    <= fix_res;
               flag      <= 1'b0;
               state     <= S_DONE;
               out_valid <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
